sub_layer_lut_iter: RTL and testbench
=====================================

// Module: sub_layer_lut_iter
// PURPOSE
//  Parametrised, iterative ASCON substitution layer with a run-time programmable 5-bit S-box LUT.
//  Processes the 5x64-bit state LANES columns per cycle; trades latency for area vs. a full 64-copy layer.
//  Sits between the constant-addition and linear-diffusion stages of the permutation core.
//  Valid/ready handshake on both sides; LUT host-writable between operations.
// PARAMETERS
//  XLEN   64  bits per state word (columns); must be a multiple of LANES
//  LANES  8   columns substituted per cycle = number of LUT read copies; power of 2, 1..XLEN
//  BEATS  XLEN/LANES (localparam) cycles per operation
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       synchronous reset, active-high
//  in_valid_i   in   1       input state valid
//  in_ready_o   out  1       block can accept a state
//  x0_i..x4_i   in   XLEN    state words in
//  out_valid_o  out  1       substituted state valid
//  out_ready_i  in   1       downstream accepts result
//  x0_o..x4_o   out  XLEN    state words out
//  lut_we_i     in   1       LUT write strobe
//  lut_wready_o out  1       LUT write accepted this cycle
//  lut_addr_i   in   5       LUT write/read address
//  lut_wdata_i  in   5       LUT write data
//  lut_rdata_o  out  5       LUT read data (combinational, copy 0)
//  lut_err_o    out  1       sticky LUT parity error (0 when SBOX_LUT_PARITY_EN undefined)
// BEHAVIOUR
//  - Column i: addr={x0[i],x1[i],x2[i],x3[i],x4[i]} (x0 MSB); data bit4..0 -> x0_o[i]..x4_o[i].
//  - Reset: FSM=IDLE, in_ready_o=1, out_valid_o=0, x*_o=0, beat cnt=0, lut_err_o=0, every LUT copy
//    loaded with ASCON S-box SBOX_INIT; reset mid-operation aborts it and discards partial state.
//  - FSM IDLE: in_ready_o=1; in_valid_i -> capture x*_i into state regs, cnt=0, go BUSY.
//  - BUSY: in_ready_o=0; each cycle substitute columns cnt*LANES..cnt*LANES+LANES-1 in place;
//    cnt++; on cnt==BEATS-1 go DONE. BUSY lasts exactly BEATS cycles.
//  - DONE: out_valid_o=1, x*_o = state regs, stable until out_ready_i; out_valid_o&out_ready_i -> IDLE.
//  - Latency accept->out_valid_o = BEATS+1 cycles; min issue interval BEATS+2 (no accept in DONE).
//  - LUT write: lut_wready_o=1 in IDLE and DONE, 0 in BUSY; write commits to all LANES copies at
//    edge when lut_we_i&lut_wready_o; lut_we_i in BUSY is ignored (host holds it until wready).
//  - Write and input accept in same IDLE cycle: write commits first, that operation uses new entry.
//  - LANES==XLEN: BEATS=1, block is a 2-cycle registered full layer.
// CONFIGURATION
//  - SBOX_LUT_PARITY_EN defined: each entry stores an even-parity bit (computed on write/reset);
//    any lane read in BUSY with mismatching parity sets lut_err_o (sticky until rst_i); data still used.
//  - Undefined: no parity storage, lut_err_o tied 0.
// STRUCTURE
//  - ascon_pkg: SBOX_INIT (32x5: 04 0b 1f 14 1a 15 09 02 1b 05 08 12 1d 03 06 1c 1e 13 07 0e 00 0d
//    11 18 10 0c 01 19 16 0a 0f 17), typedef sbox_entry_t [4:0], FSM enum state_e {IDLE,BUSY,DONE}.
//  - One sub-module sbox_lut_bank: 32x5 reg array, sync write, LANES combinational read ports.
// TESTING
//  - All x*_i=0, LANES=8 -> out_valid 9 cycles after accept; x2_o=all ones, x0/x1/x3/x4_o=0.
//  - All x*_i=ones -> entry 31 (0x17): x0,x2,x3,x4_o=ones, x1_o=0; repeat LANES=1 (65 cyc) and 64 (2 cyc).
//  - Write addr 0 <- 0x1f in IDLE, zero state -> all x*_o=ones; lut_rdata_o(0)=0x1f; reset restores 0x04.
//  - lut_we_i asserted during BUSY -> lut_wready_o=0, table unchanged until DONE, then committed.
//  - out_ready_i held 0 for 10 cycles in DONE -> out_valid_o, x*_o stable, in_ready_o=0; rst_i mid-BUSY -> IDLE, out_valid_o=0.
//  - SBOX_LUT_PARITY_EN: force flipped entry bit, run op using it -> lut_err_o=1 sticky until rst_i.

Source files
------------

// File: rtl/sub_layer_lut_iter_pkg.sv
// Shared types and constants for the iterative LUT-based ASCON substitution layer.
//   sbox_entry_t : one 5-bit S-box entry
//   state_e      : control FSM states
//   SBOX_INIT    : ASCON S-box, loaded into every LUT copy at reset
package sub_layer_lut_iter_pkg;

  localparam int unsigned SBOX_W = 5;
  localparam int unsigned SBOX_N = 32;
  localparam int unsigned NWORDS = 5;

  typedef logic [SBOX_W-1:0] sbox_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam sbox_entry_t SBOX_INIT [SBOX_N] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // Even-parity bit for an entry: data plus parity always holds an even number of ones.
  function automatic logic even_par(sbox_entry_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/sub_layer_lut_iter_if.sv
// State stream bundle for the substitution layer.
//   in_valid_i/in_ready_o  : input state handshake, x0_i..x4_i state words in
//   out_valid_o/out_ready_i: output state handshake, x0_o..x4_o state words out
//   slave modport is the layer side, master modport is the producer/consumer side.
interface sub_layer_lut_iter_if #(
  parameter int unsigned XLEN = 64
);

  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] x0_i;
  logic [XLEN-1:0] x1_i;
  logic [XLEN-1:0] x2_i;
  logic [XLEN-1:0] x3_i;
  logic [XLEN-1:0] x4_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] x0_o;
  logic [XLEN-1:0] x1_o;
  logic [XLEN-1:0] x2_o;
  logic [XLEN-1:0] x3_o;
  logic [XLEN-1:0] x4_o;

  modport slave (
    input  in_valid_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
    output in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o
  );

  modport master (
    output in_valid_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
    input  in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o
  );

endinterface

// File: rtl/sub_layer_lut_iter_lut_bank.sv
// Programmable 32x5 S-box table with LANES combinational lookup ports and one host read port.
// All lookup copies hold identical contents, so a single array backs every port.
// Optional macro SBOX_LUT_PARITY_EN adds a stored even-parity bit per entry and a per-lane
// parity-mismatch flag.
//   clk_i, rst_i : clock, synchronous active-high reset (reloads SBOX_INIT)
//   i_we         : write strobe (already qualified by the caller)
//   i_waddr/i_wdata : write address/data
//   i_raddr/o_rdata : per-lane lookup address/data
//   i_haddr/o_hdata : host read address/data
//   o_perr       : per-lane parity mismatch (parity build only)
module sbox_lut_bank
  import sub_layer_lut_iter_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_we,
  input  sbox_entry_t i_waddr,
  input  sbox_entry_t i_wdata,
  input  sbox_entry_t i_raddr [LANES],
  output sbox_entry_t o_rdata [LANES],
  input  sbox_entry_t i_haddr,
  output sbox_entry_t o_hdata
`ifdef SBOX_LUT_PARITY_EN
  ,
  output logic [LANES-1:0] o_perr
`endif
);

  sbox_entry_t r_mem [SBOX_N];

  // Table storage: reset reload, single write port shared by all copies.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SBOX_N; i++) begin
        r_mem[i] <= SBOX_INIT[i];
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Lane lookups.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      o_rdata[l] = r_mem[i_raddr[l]];
    end
  end

  assign o_hdata = r_mem[i_haddr];

`ifdef SBOX_LUT_PARITY_EN
  logic [SBOX_N-1:0] r_par;

  // Parity is recomputed from the data on every reload or write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SBOX_N; i++) begin
        r_par[i] <= even_par(SBOX_INIT[i]);
      end
    end else if (i_we) begin
      r_par[i_waddr] <= even_par(i_wdata);
    end
  end

  // A lane flags an error when stored data and stored parity disagree.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      o_perr[l] = even_par(r_mem[i_raddr[l]]) ^ r_par[i_raddr[l]];
    end
  end
`endif

endmodule

// File: rtl/sub_layer_lut_iter.sv
// Iterative ASCON substitution layer with a run-time programmable S-box table.
// Substitutes LANES columns of the 5xXLEN state per cycle; one operation takes
// BEATS = XLEN/LANES busy cycles, result valid BEATS+1 cycles after accept.
// Optional macro SBOX_LUT_PARITY_EN: per-entry parity with sticky error flag.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   bus_if         : state stream (slave modport of sub_layer_lut_iter_if)
//   lut_we_i       : table write strobe, held by host until lut_wready_o
//   lut_wready_o   : write commits this cycle (IDLE or DONE)
//   lut_addr_i     : table write/read address
//   lut_wdata_i    : table write data
//   lut_rdata_o    : combinational table read at lut_addr_i
//   lut_err_o      : sticky parity error (constant 0 without the macro)
module sub_layer_lut_iter
  import sub_layer_lut_iter_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned LANES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sub_layer_lut_iter_if.slave  bus_if,
  input  logic                 lut_we_i,
  output logic                 lut_wready_o,
  input  logic [4:0]           lut_addr_i,
  input  logic [4:0]           lut_wdata_i,
  output logic [4:0]           lut_rdata_o,
  output logic                 lut_err_o
);

  localparam int unsigned BEATS = XLEN / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IDX_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_x [NWORDS];
  logic [IDX_W-1:0]  w_base;
  logic              w_last;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_wready;
  logic              w_busy;
  sbox_entry_t       w_raddr [LANES];
  sbox_entry_t       w_rdata [LANES];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_last = (r_cnt == CNT_W'(BEATS - 1));

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus_if.in_valid_i)  w_state_nxt = BUSY;
      BUSY:    if (w_last)             w_state_nxt = DONE;
      DONE:    if (bus_if.out_ready_i) w_state_nxt = IDLE;
      default:                         w_state_nxt = IDLE;
    endcase
  end

  // State-decoded control outputs; no input accept in DONE.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_wready    = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_wready   = 1'b1;
      end
      BUSY: w_busy = 1'b1;
      DONE: begin
        w_out_valid = 1'b1;
        w_wready    = 1'b1;
      end
      default: ;
    endcase
  end

  // First column handled this beat; LANES is a power of two so the product stays in range.
  assign w_base = IDX_W'(r_cnt) * IDX_W'(LANES);

  // Column address: x0 bit is the MSB of the S-box index.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_raddr[l] = {r_x[0][w_base + IDX_W'(l)],
                    r_x[1][w_base + IDX_W'(l)],
                    r_x[2][w_base + IDX_W'(l)],
                    r_x[3][w_base + IDX_W'(l)],
                    r_x[4][w_base + IDX_W'(l)]};
    end
  end

  // State capture and in-place column substitution.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      for (int unsigned k = 0; k < NWORDS; k++) begin
        r_x[k] <= '0;
      end
    end else begin
      if (w_in_ready && bus_if.in_valid_i) begin
        r_x[0] <= bus_if.x0_i;
        r_x[1] <= bus_if.x1_i;
        r_x[2] <= bus_if.x2_i;
        r_x[3] <= bus_if.x3_i;
        r_x[4] <= bus_if.x4_i;
        r_cnt  <= '0;
      end else if (w_busy) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          r_x[0][w_base + IDX_W'(l)] <= w_rdata[l][4];
          r_x[1][w_base + IDX_W'(l)] <= w_rdata[l][3];
          r_x[2][w_base + IDX_W'(l)] <= w_rdata[l][2];
          r_x[3][w_base + IDX_W'(l)] <= w_rdata[l][1];
          r_x[4][w_base + IDX_W'(l)] <= w_rdata[l][0];
        end
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SBOX_LUT_PARITY_EN
  logic [LANES-1:0] w_perr;
  logic             r_err;
`endif

  // Table write is blocked while BUSY so an operation sees one consistent table.
  sbox_lut_bank #(
    .LANES (LANES)
  ) u_bank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_we    (lut_we_i & w_wready),
    .i_waddr (lut_addr_i),
    .i_wdata (lut_wdata_i),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata),
    .i_haddr (lut_addr_i),
    .o_hdata (lut_rdata_o)
`ifdef SBOX_LUT_PARITY_EN
    ,
    .o_perr  (w_perr)
`endif
  );

`ifdef SBOX_LUT_PARITY_EN
  // Sticky error: any mismatching lane read during an operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_busy && (|w_perr)) begin
      r_err <= 1'b1;
    end
  end

  assign lut_err_o = r_err;
`else
  assign lut_err_o = 1'b0;
`endif

  assign bus_if.in_ready_o  = w_in_ready;
  assign bus_if.out_valid_o = w_out_valid;
  assign lut_wready_o       = w_wready;

  // Result words are only presented while valid; zero otherwise.
  assign bus_if.x0_o = w_out_valid ? r_x[0] : '0;
  assign bus_if.x1_o = w_out_valid ? r_x[1] : '0;
  assign bus_if.x2_o = w_out_valid ? r_x[2] : '0;
  assign bus_if.x3_o = w_out_valid ? r_x[3] : '0;
  assign bus_if.x4_o = w_out_valid ? r_x[4] : '0;

endmodule

// File: tb/tb_sub_layer_lut_iter.sv
// Self-checking bench for sub_layer_lut_iter: LANES=8 main instance plus LANES=1 and LANES=64
// instances for latency corner cases. Expected states come from a bench-side S-box model.
module tb_sub_layer_lut_iter;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } st_t;

  localparam logic [4:0] TB_SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam logic [63:0] ONES = '1;

  logic       clk;
  logic       rst;
  logic       we;
  logic       wready;
  logic [4:0] addr;
  logic [4:0] wdata;
  logic [4:0] rdata;
  logic       err;
  logic       t_we;
  logic [4:0] t_addr;
  logic [4:0] t_wdata;
  logic       wready1, wready64, err1, err64;
  logic [4:0] rdata1, rdata64;

  logic [4:0] m_lut [32];
  st_t        exp_q [$];
  int         n_pass;
  int         n_total;

  sub_layer_lut_iter_if #(.XLEN(64)) bus8 ();
  sub_layer_lut_iter_if #(.XLEN(64)) bus1 ();
  sub_layer_lut_iter_if #(.XLEN(64)) bus64 ();

  sub_layer_lut_iter #(.XLEN(64), .LANES(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus_if(bus8),
    .lut_we_i(we), .lut_wready_o(wready), .lut_addr_i(addr),
    .lut_wdata_i(wdata), .lut_rdata_o(rdata), .lut_err_o(err)
  );

  sub_layer_lut_iter #(.XLEN(64), .LANES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus_if(bus1),
    .lut_we_i(t_we), .lut_wready_o(wready1), .lut_addr_i(t_addr),
    .lut_wdata_i(t_wdata), .lut_rdata_o(rdata1), .lut_err_o(err1)
  );

  sub_layer_lut_iter #(.XLEN(64), .LANES(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .bus_if(bus64),
    .lut_we_i(t_we), .lut_wready_o(wready64), .lut_addr_i(t_addr),
    .lut_wdata_i(t_wdata), .lut_rdata_o(rdata64), .lut_err_o(err64)
  );

  always #5 clk = ~clk;

  function automatic st_t model(st_t s);
    st_t        r;
    logic [4:0] a;
    logic [4:0] d;
    r = s;
    for (int c = 0; c < 64; c++) begin
      a = {s.x0[c], s.x1[c], s.x2[c], s.x3[c], s.x4[c]};
      d = m_lut[a];
      r.x0[c] = d[4];
      r.x1[c] = d[3];
      r.x2[c] = d[2];
      r.x3[c] = d[1];
      r.x4[c] = d[0];
    end
    return r;
  endfunction

  function automatic st_t got8();
    return st_t'({bus8.x0_o, bus8.x1_o, bus8.x2_o, bus8.x3_o, bus8.x4_o});
  endfunction

  function automatic st_t rnd_st();
    return st_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus8.in_valid_i = 1'b0;
    bus8.out_ready_i = 1'b0;
    we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_lut[i] = TB_SBOX[i];
    exp_q.delete();
  endtask

  // Drive one state on the main instance and record its expected result.
  task automatic send(input st_t s);
    int k;
    @(negedge clk);
    bus8.in_valid_i = 1'b1;
    {bus8.x0_i, bus8.x1_i, bus8.x2_i, bus8.x3_i, bus8.x4_i} = s;
    k = 0;
    while (!bus8.in_ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    exp_q.push_back(model(s));
    @(posedge clk);
    #1;
    bus8.in_valid_i = 1'b0;
  endtask

  // Cycles counted from the accept cycle until out_valid_o is seen.
  task automatic wait_out8(output int n);
    n = 1;
    while (!bus8.out_valid_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic ack8();
    bus8.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    st_t zero;
    zero = '0;
    reset_dut();
    n_total++; if (bus8.in_ready_o !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus8.in_ready_o); else n_pass++;
    n_total++; if (bus8.out_valid_o !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus8.out_valid_o); else n_pass++;
    n_total++; if (got8() !== zero) $display("FAIL reset_x_out got %h exp 0", got8()); else n_pass++;
    n_total++; if (wready !== 1'b1) $display("FAIL reset_wready got %b exp 1", wready); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    n_total++; if (rdata !== 5'h04) $display("FAIL reset_rdata0 got %h exp 04", rdata); else n_pass++;
    n_total++; if (rdata1 !== 5'h04 || rdata64 !== 5'h04) $display("FAIL reset_rdata_var got %h/%h exp 04", rdata1, rdata64); else n_pass++;
    n_total++; if ({wready1, wready64, err1, err64} !== 4'b1100) $display("FAIL reset_var_flags got %b exp 1100", {wready1, wready64, err1, err64}); else n_pass++;
  endtask

  task automatic test_zero_state();
    int  n;
    st_t e;
    send('0);
    wait_out8(n);
    n_total++; if (n !== 9) $display("FAIL zero_latency got %0d exp 9", n); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if (got8() !== e) $display("FAIL zero_data got %h exp %h", got8(), e); else n_pass++;
    n_total++; if (bus8.x2_o !== ONES || (bus8.x0_o | bus8.x1_o | bus8.x3_o | bus8.x4_o) !== 64'h0)
      $display("FAIL zero_words got x2=%h others_or=%h exp x2 ones others 0", bus8.x2_o, bus8.x0_o | bus8.x1_o | bus8.x3_o | bus8.x4_o);
    else n_pass++;
    ack8();
  endtask

  task automatic test_ones_lanes();
    int  n;
    st_t s;
    st_t e;
    s = st_t'({5{ONES}});
    // LANES=8
    send(s);
    wait_out8(n);
    e = exp_q.pop_front();
    n_total++; if (n !== 9) $display("FAIL ones8_latency got %0d exp 9", n); else n_pass++;
    n_total++; if (got8() !== e || bus8.x1_o !== 64'h0 || bus8.x3_o !== ONES)
      $display("FAIL ones8_data got %h exp %h", got8(), e); else n_pass++;
    ack8();
    // LANES=1
    @(negedge clk);
    bus1.in_valid_i = 1'b1;
    {bus1.x0_i, bus1.x1_i, bus1.x2_i, bus1.x3_i, bus1.x4_i} = s;
    @(posedge clk);
    #1;
    bus1.in_valid_i = 1'b0;
    n = 1;
    while (!bus1.out_valid_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_total++; if (n !== 65) $display("FAIL ones1_latency got %0d exp 65", n); else n_pass++;
    n_total++; if ({bus1.x0_o, bus1.x1_o, bus1.x2_o, bus1.x3_o, bus1.x4_o} !== {ONES, 64'h0, ONES, ONES, ONES})
      $display("FAIL ones1_data got %h %h %h %h %h", bus1.x0_o, bus1.x1_o, bus1.x2_o, bus1.x3_o, bus1.x4_o); else n_pass++;
    bus1.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready_i = 1'b0;
    // LANES=64
    @(negedge clk);
    bus64.in_valid_i = 1'b1;
    {bus64.x0_i, bus64.x1_i, bus64.x2_i, bus64.x3_i, bus64.x4_i} = s;
    @(posedge clk);
    #1;
    bus64.in_valid_i = 1'b0;
    n = 1;
    while (!bus64.out_valid_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_total++; if (n !== 2) $display("FAIL ones64_latency got %0d exp 2", n); else n_pass++;
    n_total++; if ({bus64.x0_o, bus64.x1_o, bus64.x2_o, bus64.x3_o, bus64.x4_o} !== {ONES, 64'h0, ONES, ONES, ONES})
      $display("FAIL ones64_data got %h %h %h %h %h", bus64.x0_o, bus64.x1_o, bus64.x2_o, bus64.x3_o, bus64.x4_o); else n_pass++;
    bus64.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus64.out_ready_i = 1'b0;
  endtask

  // Table write and input accept in the same IDLE cycle; then reset restores the table.
  task automatic test_lut_write();
    int  n;
    st_t e;
    @(negedge clk);
    we = 1'b1;
    addr = 5'd0;
    wdata = 5'h1f;
    bus8.in_valid_i = 1'b1;
    {bus8.x0_i, bus8.x1_i, bus8.x2_i, bus8.x3_i, bus8.x4_i} = '0;
    #1;
    n_total++; if (wready !== 1'b1 || bus8.in_ready_o !== 1'b1)
      $display("FAIL wr_idle_ready got wready=%b in_ready=%b exp 1/1", wready, bus8.in_ready_o); else n_pass++;
    m_lut[0] = 5'h1f;
    exp_q.push_back(model('0));
    @(posedge clk);
    #1;
    we = 1'b0;
    bus8.in_valid_i = 1'b0;
    n_total++; if (rdata !== 5'h1f) $display("FAIL wr_rdata got %h exp 1f", rdata); else n_pass++;
    wait_out8(n);
    e = exp_q.pop_front();
    n_total++; if (n !== 9) $display("FAIL wr_latency got %0d exp 9", n); else n_pass++;
    n_total++; if (got8() !== e || got8() !== st_t'({5{ONES}})) $display("FAIL wr_data got %h exp %h", got8(), e); else n_pass++;
    ack8();
    reset_dut();
    n_total++; if (rdata !== 5'h04) $display("FAIL wr_reset_restore got %h exp 04", rdata); else n_pass++;
  endtask

  // Write held during BUSY is deferred until DONE.
  task automatic test_write_busy();
    int  n;
    st_t e;
    send('0);
    @(negedge clk);
    we = 1'b1;
    addr = 5'd0;
    wdata = 5'h1f;
    #1;
    n_total++; if (wready !== 1'b0) $display("FAIL wb_wready_busy got %b exp 0", wready); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (rdata !== 5'h04) $display("FAIL wb_table_busy got %h exp 04", rdata); else n_pass++;
    n = 0;
    while (!bus8.out_valid_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_total++; if (bus8.out_valid_o !== 1'b1) $display("FAIL wb_timeout got out_valid=%b exp 1", bus8.out_valid_o); else n_pass++;
    n_total++; if (wready !== 1'b1) $display("FAIL wb_wready_done got %b exp 1", wready); else n_pass++;
    e = exp_q.pop_front();
    n_total++; if (got8() !== e) $display("FAIL wb_data got %h exp %h", got8(), e); else n_pass++;
    @(posedge clk);
    #1;
    we = 1'b0;
    m_lut[0] = 5'h1f;
    n_total++; if (rdata !== 5'h1f) $display("FAIL wb_commit got %h exp 1f", rdata); else n_pass++;
    n_total++; if (got8() !== e) $display("FAIL wb_data_after_write got %h exp %h", got8(), e); else n_pass++;
    ack8();
    reset_dut();
  endtask

  task automatic test_stall();
    int  n;
    st_t e;
    send(rnd_st());
    wait_out8(n);
    e = exp_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      n_total++; if (bus8.out_valid_o !== 1'b1) $display("FAIL stall_valid cyc %0d got %b exp 1", c, bus8.out_valid_o); else n_pass++;
      n_total++; if (got8() !== e) $display("FAIL stall_data cyc %0d got %h exp %h", c, got8(), e); else n_pass++;
      n_total++; if (bus8.in_ready_o !== 1'b0) $display("FAIL stall_in_ready cyc %0d got %b exp 0", c, bus8.in_ready_o); else n_pass++;
      @(posedge clk);
      #1;
    end
    ack8();
  endtask

  task automatic test_back_to_back();
    st_t items [4];
    int  acc [4];
    int  idx;
    int  done;
    int  cyc;
    st_t e;
    for (int i = 0; i < 4; i++) items[i] = rnd_st();
    idx = 0;
    done = 0;
    cyc = 0;
    bus8.out_ready_i = 1'b1;
    while (done < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus8.in_valid_i = (idx < 4);
      if (idx < 4) {bus8.x0_i, bus8.x1_i, bus8.x2_i, bus8.x3_i, bus8.x4_i} = items[idx];
      #1;
      if (bus8.out_valid_o && bus8.out_ready_i) begin
        e = exp_q.pop_front();
        n_total++; if (got8() !== e) $display("FAIL b2b_data %0d got %h exp %h", done, got8(), e); else n_pass++;
        done++;
      end
      if (bus8.in_valid_i && bus8.in_ready_o) begin
        exp_q.push_back(model(items[idx]));
        acc[idx] = cyc;
        idx++;
      end
    end
    @(negedge clk);
    bus8.in_valid_i = 1'b0;
    bus8.out_ready_i = 1'b0;
    n_total++; if (done !== 4) $display("FAIL b2b_count got %0d exp 4", done); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_total++; if (acc[i] - acc[i-1] !== 10) $display("FAIL b2b_interval %0d got %0d exp 10", i, acc[i] - acc[i-1]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_busy();
    st_t zero;
    zero = '0;
    send(rnd_st());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (bus8.out_valid_o !== 1'b0 || bus8.in_ready_o !== 1'b1)
      $display("FAIL midrst_state got out_valid=%b in_ready=%b exp 0/1", bus8.out_valid_o, bus8.in_ready_o); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (12) @(posedge clk);
    #1;
    n_total++; if (bus8.out_valid_o !== 1'b0 || got8() !== zero)
      $display("FAIL midrst_discard got out_valid=%b x=%h exp 0", bus8.out_valid_o, got8()); else n_pass++;
  endtask

`ifdef SBOX_LUT_PARITY_EN
  task automatic test_parity();
    int  n;
    st_t e;
    force u_dut.u_bank.r_mem[31] = 5'h16;
    send(st_t'({5{ONES}}));
    wait_out8(n);
    e = exp_q.pop_front();
    n_total++; if (err !== 1'b1) $display("FAIL parity_set got %b exp 1", err); else n_pass++;
    ack8();
    release u_dut.u_bank.r_mem[31];
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (err !== 1'b1) $display("FAIL parity_sticky got %b exp 1", err); else n_pass++;
    reset_dut();
    n_total++; if (err !== 1'b0) $display("FAIL parity_clear got %b exp 0", err); else n_pass++;
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_pass = 0;
    n_total = 0;
    we = 1'b0;
    addr = 5'd0;
    wdata = 5'd0;
    t_we = 1'b0;
    t_addr = 5'd0;
    t_wdata = 5'd0;
    bus8.in_valid_i = 1'b0;
    bus8.out_ready_i = 1'b0;
    {bus8.x0_i, bus8.x1_i, bus8.x2_i, bus8.x3_i, bus8.x4_i} = '0;
    bus1.in_valid_i = 1'b0;
    bus1.out_ready_i = 1'b0;
    {bus1.x0_i, bus1.x1_i, bus1.x2_i, bus1.x3_i, bus1.x4_i} = '0;
    bus64.in_valid_i = 1'b0;
    bus64.out_ready_i = 1'b0;
    {bus64.x0_i, bus64.x1_i, bus64.x2_i, bus64.x3_i, bus64.x4_i} = '0;

    test_reset();
    test_zero_state();
    test_ones_lanes();
    test_lut_write();
    test_write_busy();
    test_stall();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef SBOX_LUT_PARITY_EN
    test_parity();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
